// File: rtl/ram_exerciser.sv
// ram_exerciser: DEPTH x DW synchronous RAM with manual read/write pointers plus an
// automatic FILL/VERIFY sequencer. Optional macro RAM_EXERCISER_ERR_INJECT_EN adds inj_err.
module ram_exerciser #(
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int PAT_INC = 1
) (
  input  logic          clk,
  input  logic          clr_n,
`ifdef RAM_EXERCISER_ERR_INJECT_EN
  input  logic          inj_err,
`endif
  input  logic          wea,
  input  logic          rd_step,
  input  logic          wr_step,
  input  logic          auto_start,
  input  logic          auto_mode,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_cnt,
  output logic          err_flag,
  output logic [2:0]    state_dbg
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [DW-1:0] INC = DW'(PAT_INC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_VERIFY = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] vidx;
  logic [DW-1:0] pat;
  logic [DW-1:0] exp_base;
  logic [DW-1:0] chk_pat;
  logic [DW-1:0] cmp_exp;
  logic          cmp_pend;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] mem [DEPTH];

  logic          we;
  logic          re;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] wdata;
  logic          inj_bit;

`ifdef RAM_EXERCISER_ERR_INJECT_EN
  assign inj_bit = inj_err;
`else
  assign inj_bit = 1'b0;
`endif

  // Step and start inputs are single-cycle pulses sampled on the rising edge; they act
  // only in IDLE, where auto_start wins over steps and a step acts only if it matches wea.
  always_comb begin
    we    = 1'b0;
    re    = 1'b0;
    waddr = wr_ptr;
    raddr = rd_ptr;
    wdata = pat;
    case (state)
      S_IDLE: begin
        if (!auto_start) begin
          we = wea && wr_step;
          re = !wea && rd_step;
        end
      end
      S_FILL: begin
        we    = 1'b1;
        wdata = pat ^ {{(DW-1){1'b0}}, inj_bit};
      end
      S_VERIFY: begin
        re    = 1'b1;
        raddr = vidx;
      end
      default: ;
    endcase
  end

  // RAM array is deliberately not reset; the read register gives old data on collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      vidx     <= '0;
      pat      <= '0;
      exp_base <= '0;
      chk_pat  <= '0;
      cmp_exp  <= '0;
      cmp_pend <= 1'b0;
      ram_q    <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (re) ram_q <= mem[raddr];
      if (cmp_pend && (ram_q != cmp_exp) && (err_cnt != '1)) err_cnt <= err_cnt + (AW+1)'(1);
      case (state)
        S_IDLE: begin
          if (auto_start) begin
            busy <= 1'b1;
            if (auto_mode) begin
              state   <= S_VERIFY;
              vidx    <= '0;
              chk_pat <= exp_base;
              err_cnt <= '0;
            end else begin
              state    <= S_FILL;
              exp_base <= pat;
              wr_ptr   <= '0;
            end
          end else if (wea && wr_step) begin
            wr_ptr <= wr_ptr + AW'(1);
            pat    <= pat + INC;
          end else if (!wea && rd_step) begin
            rd_ptr   <= rd_ptr + AW'(1);
            rd_valid <= 1'b1;
          end
        end
        // wr_ptr walks the array and wraps back to 0; pat ends at exp_base + DEPTH*INC.
        S_FILL: begin
          wr_ptr <= wr_ptr + AW'(1);
          pat    <= pat + INC;
          if (&wr_ptr) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_VERIFY: begin
          vidx     <= vidx + AW'(1);
          cmp_exp  <= chk_pat;
          chk_pat  <= chk_pat + INC;
          cmp_pend <= 1'b1;
          if (&vidx) state <= S_FLUSH;
        end
        S_FLUSH: begin
          cmp_pend <= 1'b0;
          state    <= S_DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr   = rd_ptr;
  assign wr_addr   = wr_ptr;
  assign rd_data   = ram_q;
  assign err_flag  = (err_cnt != '0);
  assign state_dbg = state;

endmodule
